// File: rtl/window_fetch_ctrl.sv
// Walks every 3x3 window anchor of a row-major image in raster order, issuing nine
// BRAM reads per window and presenting the gathered pixels on a valid/ready handshake.
module window_fetch_ctrl #(
  parameter int IMG_W  = 50,
  parameter int IMG_H  = 50,
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic [9*PIX_W-1:0]   win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [5:0]           win_row,
  output logic [5:0]           win_col,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_DONE} state_t;

  state_t              state, state_n;
  logic [3:0]          fcnt, fcnt_n;
  logic [DW-1:0]       dcnt, dcnt_n;
  logic [ADDR_W-1:0]   base, base_n;
  logic [5:0]          row_n, col_n;
  logic                rd_en_n, valid_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                last;
  logic                pipe_v [RD_LAT];
  logic [3:0]          pipe_s [RD_LAT];

  function automatic logic [ADDR_W-1:0] offset(input logic [3:0] k);
    case (k)
      4'd0:    offset = '0;
      4'd1:    offset = ADDR_W'(1);
      4'd2:    offset = ADDR_W'(2);
      4'd3:    offset = ADDR_W'(IMG_W);
      4'd4:    offset = ADDR_W'(IMG_W + 1);
      4'd5:    offset = ADDR_W'(IMG_W + 2);
      4'd6:    offset = ADDR_W'(2 * IMG_W);
      4'd7:    offset = ADDR_W'(2 * IMG_W + 1);
      4'd8:    offset = ADDR_W'(2 * IMG_W + 2);
      default: offset = '0;
    endcase
  endfunction

  assign last = (win_row == 6'(IMG_H - 3)) && (win_col == 6'(IMG_W - 3));

  // Registered outputs are loaded from their next-cycle values so that the read
  // strobe and address line up with the state they belong to.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    dcnt_n  = dcnt;
    base_n  = base;
    row_n   = win_row;
    col_n   = win_col;
    rd_en_n = 1'b0;
    addr_n  = '0;
    valid_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          fcnt_n  = '0;
          base_n  = '0;
          row_n   = '0;
          col_n   = '0;
          rd_en_n = 1'b1;
        end
      end
      S_FETCH: begin
        if (fcnt == 4'd8) begin
          state_n = S_DRAIN;
          dcnt_n  = '0;
        end else begin
          fcnt_n  = fcnt + 4'd1;
          rd_en_n = 1'b1;
          addr_n  = base + offset(fcnt + 4'd1);
        end
      end
      S_DRAIN: begin
        if (dcnt == DW'(RD_LAT - 1)) begin
          state_n = S_PRESENT;
          valid_n = 1'b1;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      S_PRESENT: begin
        valid_n = 1'b1;
        if (win_ready) begin
          valid_n = 1'b0;
          if (last) begin
            state_n = S_DONE;
          end else begin
            if (win_col < 6'(IMG_W - 3)) begin
              col_n  = win_col + 6'd1;
              base_n = base + ADDR_W'(1);
            end else begin
              col_n  = '0;
              row_n  = win_row + 6'd1;
              base_n = base + ADDR_W'(3);
            end
            state_n = S_FETCH;
            fcnt_n  = '0;
            rd_en_n = 1'b1;
            addr_n  = base_n;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        base_n  = '0;
        row_n   = '0;
        col_n   = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fcnt      <= '0;
      dcnt      <= '0;
      base      <= '0;
      win_row   <= '0;
      win_col   <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_s[i] <= '0;
      end
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      dcnt      <= dcnt_n;
      base      <= base_n;
      win_row   <= row_n;
      win_col   <= col_n;
      mem_rd_en <= rd_en_n;
      mem_addr  <= addr_n;
      win_valid <= valid_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      // Slot tag travels with each read so the returned pixel lands in its slot.
      pipe_v[0] <= mem_rd_en;
      pipe_s[0] <= fcnt;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_s[i] <= pipe_s[i-1];
      end
      if (pipe_v[RD_LAT-1])
        win_data[pipe_s[RD_LAT-1]*PIX_W +: PIX_W] <= mem_rdata;
    end
  end

endmodule
